// File: rtl/tl_ul_a_arbiter_2to1.sv
// 2:1 TileLink-UL A-channel arbiter: round-robin, Put-burst lock, source-bit D routing; TL_ARB_INFLIGHT_LIMIT_EN adds per-client throttling.
// Zero latency on A and D; the loser sees a_ready=0, a stalled grant is frozen, D ready follows the routed client.
`timescale 1ns/1ps
module tl_ul_a_arbiter_2to1 #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 64,
    parameter int SRC_W        = 1,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                c0_a_valid,
    output logic                c0_a_ready,
    input  logic [2:0]          c0_a_opcode,
    input  logic [2:0]          c0_a_param,
    input  logic [2:0]          c0_a_size,
    input  logic [SRC_W-1:0]    c0_a_source,
    input  logic [ADDR_W-1:0]   c0_a_address,
    input  logic [DATA_W/8-1:0] c0_a_mask,
    input  logic [DATA_W-1:0]   c0_a_data,

    input  logic                c1_a_valid,
    output logic                c1_a_ready,
    input  logic [2:0]          c1_a_opcode,
    input  logic [2:0]          c1_a_param,
    input  logic [2:0]          c1_a_size,
    input  logic [SRC_W-1:0]    c1_a_source,
    input  logic [ADDR_W-1:0]   c1_a_address,
    input  logic [DATA_W/8-1:0] c1_a_mask,
    input  logic [DATA_W-1:0]   c1_a_data,

    output logic                m_a_valid,
    input  logic                m_a_ready,
    output logic [2:0]          m_a_opcode,
    output logic [2:0]          m_a_param,
    output logic [2:0]          m_a_size,
    output logic [SRC_W:0]      m_a_source,
    output logic [ADDR_W-1:0]   m_a_address,
    output logic [DATA_W/8-1:0] m_a_mask,
    output logic [DATA_W-1:0]   m_a_data,

    input  logic                m_d_valid,
    output logic                m_d_ready,
    input  logic [2:0]          m_d_opcode,
    input  logic [2:0]          m_d_param,
    input  logic [2:0]          m_d_size,
    input  logic [SRC_W:0]      m_d_source,
    input  logic [DATA_W-1:0]   m_d_data,
    input  logic                m_d_denied,
    input  logic                m_d_corrupt,

    output logic                c0_d_valid,
    input  logic                c0_d_ready,
    output logic [2:0]          c0_d_opcode,
    output logic [2:0]          c0_d_param,
    output logic [2:0]          c0_d_size,
    output logic [SRC_W-1:0]    c0_d_source,
    output logic [DATA_W-1:0]   c0_d_data,
    output logic                c0_d_denied,
    output logic                c0_d_corrupt,

    output logic                c1_d_valid,
    input  logic                c1_d_ready,
    output logic [2:0]          c1_d_opcode,
    output logic [2:0]          c1_d_param,
    output logic [2:0]          c1_d_size,
    output logic [SRC_W-1:0]    c1_d_source,
    output logic [DATA_W-1:0]   c1_d_data,
    output logic                c1_d_denied,
    output logic                c1_d_corrupt
);

    localparam int         MASK_W          = DATA_W / 8;
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    if (MAX_INFLIGHT < 1 || SRC_W < 1) begin : g_bad_cfg
        $error("tl_ul_a_arbiter_2to1: MAX_INFLIGHT and SRC_W must be at least 1");
    end

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [2:0]        size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } a_req_t;

    function automatic logic [3:0] beats_of(input logic [2:0] size);
        case (size)
            3'd4:       return 4'd2;
            3'd5:       return 4'd4;
            3'd6, 3'd7: return 4'd8;
            default:    return 4'd1;
        endcase
    endfunction

    a_req_t     c0_req;
    a_req_t     c1_req;
    a_req_t     sel_req;
    logic       rr_last;
    logic       lock;
    logic       lock_owner;
    logic       hold;
    logic       hold_owner;
    logic [2:0] beats_left;
    logic [2:0] d_beats_left;
    logic [1:0] raw_v;
    logic [1:0] elig;
    logic       win;
    logic       a_fire;
    logic       first_fire;
    logic [3:0] a_beats;
    logic       d_sel;
    logic       d_fire;
    logic [3:0] d_beats;
    logic       d_multi_first;

    assign c0_req = {c0_a_opcode, c0_a_param, c0_a_size, c0_a_source,
                     c0_a_address, c0_a_mask, c0_a_data};
    assign c1_req = {c1_a_opcode, c1_a_param, c1_a_size, c1_a_source,
                     c1_a_address, c1_a_mask, c1_a_data};
    assign raw_v  = {c1_a_valid, c0_a_valid};

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] inflight [2];
    logic             d_msg_end;
    logic [1:0]       a_inc;
    logic [1:0]       d_dec;

    // A full client only loses eligibility for new grants; lock/hold use raw valid.
    assign elig[0]   = c0_a_valid & (inflight[0] != CNT_W'(MAX_INFLIGHT));
    assign elig[1]   = c1_a_valid & (inflight[1] != CNT_W'(MAX_INFLIGHT));
    assign d_msg_end = d_fire & ((d_beats_left == 3'd1) |
                                 ((d_beats_left == 3'd0) & ~d_multi_first));
    assign a_inc     = {first_fire & win, first_fire & ~win};
    assign d_dec     = {d_msg_end & d_sel, d_msg_end & ~d_sel};

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight[0] <= '0;
            inflight[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (a_inc[c] & ~d_dec[c]) begin
                    inflight[c] <= inflight[c] + CNT_W'(1);
                end else if (~a_inc[c] & d_dec[c] & (inflight[c] != '0)) begin
                    inflight[c] <= inflight[c] - CNT_W'(1);
                end
            end
        end
    end
`else
    assign elig = raw_v;
`endif

    always_comb begin
        if (lock) begin
            win = lock_owner;
        end else if (hold) begin
            win = hold_owner;
        end else if (elig[0] & elig[1]) begin
            win = ~rr_last;
        end else begin
            win = elig[1];
        end
    end

    assign sel_req    = win ? c1_req : c0_req;
    assign m_a_valid  = (lock | hold) ? raw_v[win] : elig[win];
    assign m_a_opcode = sel_req.opcode;
    assign m_a_param  = sel_req.param;
    assign m_a_size   = sel_req.size;
    assign m_a_source = {win, sel_req.source};
    assign m_a_address = sel_req.address;
    assign m_a_mask   = sel_req.mask;
    assign m_a_data   = sel_req.data;
    assign c0_a_ready = m_a_ready & m_a_valid & ~win;
    assign c1_a_ready = m_a_ready & m_a_valid & win;

    assign a_fire     = m_a_valid & m_a_ready;
    assign first_fire = a_fire & ~lock;
    assign a_beats    = beats_of(sel_req.size);

    // D fields fan out to both clients; only the selected one sees valid.
    assign d_sel         = m_d_source[SRC_W];
    assign c0_d_valid    = m_d_valid & ~d_sel;
    assign c1_d_valid    = m_d_valid & d_sel;
    assign m_d_ready     = d_sel ? c1_d_ready : c0_d_ready;
    assign d_fire        = m_d_valid & m_d_ready;
    assign d_beats       = beats_of(m_d_size);
    assign d_multi_first = (d_beats_left == 3'd0) & (m_d_opcode == ACCESS_ACK_DATA) &
                           (d_beats > 4'd1);

    assign c0_d_opcode  = m_d_opcode;
    assign c0_d_param   = m_d_param;
    assign c0_d_size    = m_d_size;
    assign c0_d_source  = m_d_source[SRC_W-1:0];
    assign c0_d_data    = m_d_data;
    assign c0_d_denied  = m_d_denied;
    assign c0_d_corrupt = m_d_corrupt;
    assign c1_d_opcode  = m_d_opcode;
    assign c1_d_param   = m_d_param;
    assign c1_d_size    = m_d_size;
    assign c1_d_source  = m_d_source[SRC_W-1:0];
    assign c1_d_data    = m_d_data;
    assign c1_d_denied  = m_d_denied;
    assign c1_d_corrupt = m_d_corrupt;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last      <= 1'b1;
            lock         <= 1'b0;
            lock_owner   <= 1'b0;
            hold         <= 1'b0;
            hold_owner   <= 1'b0;
            beats_left   <= 3'd0;
            d_beats_left <= 3'd0;
        end else begin
            // Freeze the grant while the manager stalls so its inputs stay stable.
            hold <= m_a_valid & ~m_a_ready;
            if (m_a_valid & ~m_a_ready) begin
                hold_owner <= win;
            end
            if (first_fire) begin
                rr_last <= win;
                if (((sel_req.opcode == PUT_FULL) || (sel_req.opcode == PUT_PARTIAL)) &&
                    (a_beats > 4'd1)) begin
                    lock       <= 1'b1;
                    lock_owner <= win;
                    beats_left <= 3'(a_beats - 4'd1);
                end
            end else if (a_fire) begin
                beats_left <= beats_left - 3'd1;
                if (beats_left == 3'd1) begin
                    lock <= 1'b0;
                end
            end
            if (d_fire) begin
                if (d_multi_first) begin
                    d_beats_left <= 3'(d_beats - 4'd1);
                end else if (d_beats_left != 3'd0) begin
                    d_beats_left <= d_beats_left - 3'd1;
                end
            end
        end
    end

endmodule
